// File: rtl/delta0_scheduler_if.sv
// Bundle of sweep request, input vectors, per-neuron result handshake and
// accumulated result vectors exchanged with delta0_scheduler.
interface delta0_scheduler_if #(
   parameter int N_OUT  = 5,
   parameter int DATA_W = 10
);
   localparam int IDX_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;

   logic                      start;
   logic [N_OUT*DATA_W-1:0]   add_val;
   logic [N_OUT*DATA_W-1:0]   out_exp;
   logic                      out_valid;
   logic                      out_ready;
   logic [IDX_W-1:0]          out_idx;
   logic                      out_sign;
   logic [DATA_W-1:0]         out_delta;
   logic [N_OUT-1:0]          sign_vec;
   logic [N_OUT*DATA_W-1:0]   delta_vec;
   logic                      busy;
   logic                      done;

   modport master (
      input  start, add_val, out_exp, out_ready,
      output out_valid, out_idx, out_sign, out_delta, sign_vec, delta_vec, busy, done
   );

   modport slave (
      output start, add_val, out_exp, out_ready,
      input  out_valid, out_idx, out_sign, out_delta, sign_vec, delta_vec, busy, done
   );
endinterface

// File: rtl/delta0_scheduler.sv
// Output-layer delta sequencer: one shared multiplier swept over N_OUT neurons.
// Define DELTA0_ROUND_EN for round-half-up instead of truncation after the shift.
module delta0_scheduler #(
   parameter int N_OUT  = 5,
   parameter int DATA_W = 10,
   parameter int FRAC_W = 9
) (
   input  logic              clk,
   input  logic              rst_n,
   delta0_scheduler_if.master bus
);
   localparam int IDX_W  = (N_OUT > 1) ? $clog2(N_OUT) : 1;
   localparam int PROD_W = 2 * DATA_W;

   typedef enum logic [1:0] {IDLE, CALC, EMIT, DONE} state_t;

   state_t                  r_state;
   state_t                  w_next;
   logic [N_OUT*DATA_W-1:0] r_add;
   logic [N_OUT*DATA_W-1:0] r_exp;
   logic [N_OUT*DATA_W-1:0] r_delta_vec;
   logic [N_OUT-1:0]        r_sign_vec;
   logic [IDX_W-1:0]        r_idx;
   logic [IDX_W-1:0]        r_out_idx;
   logic                    r_out_sign;
   logic [DATA_W-1:0]       r_out_delta;

   logic [DATA_W-1:0]       w_a;
   logic [DATA_W-1:0]       w_e;
   logic [DATA_W-1:0]       w_mag;
   logic [PROD_W-1:0]       w_prod;
   logic [PROD_W:0]         w_shift;
   logic [DATA_W-1:0]       w_res;
   logic                    w_last;
   logic                    w_hs;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of process ordering.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_next;
   end

   // NOTE: w_next gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      w_next = r_state;
      case (r_state)
         IDLE:    if (bus.start) w_next = CALC;
         CALC:    w_next = EMIT;
         EMIT:    if (bus.out_ready) w_next = w_last ? DONE : CALC;
         DONE:    w_next = IDLE;
         default: w_next = IDLE;
      endcase
   end

   assign w_last = (r_idx == IDX_W'(N_OUT - 1));
   assign w_hs   = (r_state == EMIT) && bus.out_ready;

   // Two's-complement magnitude; the most negative value wraps to 2^(DATA_W-1) unsigned.
   assign w_a    = r_add[r_idx*DATA_W +: DATA_W];
   assign w_e    = r_exp[r_idx*DATA_W +: DATA_W];
   assign w_mag  = w_a[DATA_W-1] ? (~w_a + 1'b1) : w_a;
   assign w_prod = PROD_W'(w_mag) * PROD_W'(w_e);

`ifdef DELTA0_ROUND_EN
   localparam logic [PROD_W:0] HALF = (PROD_W+1)'(1) << (FRAC_W - 1);
   assign w_shift = ({1'b0, w_prod} + HALF) >> FRAC_W;
`else
   assign w_shift = {1'b0, w_prod} >> FRAC_W;
`endif

   assign w_res = (|w_shift[PROD_W:DATA_W]) ? '1 : w_shift[DATA_W-1:0];

   // NOTE: the latched operand vectors are reset too, so every register starts at 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_add       <= '0;
         r_exp       <= '0;
         r_idx       <= '0;
         r_sign_vec  <= '0;
         r_delta_vec <= '0;
         r_out_idx   <= '0;
         r_out_sign  <= 1'b0;
         r_out_delta <= '0;
      end else begin
         if (r_state == IDLE && bus.start) begin
            r_add       <= bus.add_val;
            r_exp       <= bus.out_exp;
            r_idx       <= '0;
            r_sign_vec  <= '0;
            r_delta_vec <= '0;
         end
         if (r_state == CALC) begin
            r_out_delta <= w_res;
            r_out_sign  <= w_a[DATA_W-1];
            r_out_idx   <= r_idx;
         end
         if (w_hs) begin
            r_sign_vec[r_idx]                  <= r_out_sign;
            r_delta_vec[r_idx*DATA_W +: DATA_W] <= r_out_delta;
            if (!w_last) r_idx <= r_idx + 1'b1;
         end
      end
   end

   // Status decodes come straight from the state register: no path from out_ready.
   assign bus.out_valid = (r_state == EMIT);
   assign bus.busy      = (r_state != IDLE);
   assign bus.done      = (r_state == DONE);
   assign bus.out_idx   = r_out_idx;
   assign bus.out_sign  = r_out_sign;
   assign bus.out_delta = r_out_delta;
   assign bus.sign_vec  = r_sign_vec;
   assign bus.delta_vec = r_delta_vec;
endmodule

// File: tb/tb_delta0_scheduler.sv
// Scoreboard bench for delta0_scheduler: main 5-neuron instance plus a
// 2-neuron FRAC_W=8 instance for saturation and most-negative-input cases.
module tb_delta0_scheduler;
   localparam int N  = 5;
   localparam int DW = 10;
   localparam int FW = 9;
   localparam int FW8 = 8;

   typedef struct {
      int   idx;
      logic sign;
      int   delta;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t sb[$];
   exp_t sb8[$];
   exp_t m_e;
   exp_t m_e8;

   delta0_scheduler_if #(.N_OUT(N), .DATA_W(DW)) d_if ();
   delta0_scheduler_if #(.N_OUT(2), .DATA_W(DW)) s_if ();

   delta0_scheduler #(.N_OUT(N), .DATA_W(DW), .FRAC_W(FW)) u_dut (
      .clk(clk), .rst_n(rst_n), .bus(d_if.master));

   delta0_scheduler #(.N_OUT(2), .DATA_W(DW), .FRAC_W(FW8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .bus(s_if.master));

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   function automatic int model_delta(input int a, input int e, input int fw);
      longint prod;
      longint res;
      prod = longint'((a < 0) ? -a : a) * longint'(e);
`ifdef DELTA0_ROUND_EN
      prod = prod + (longint'(1) << (fw - 1));
`endif
      res = prod >>> fw;
      if (res > longint'((1 << DW) - 1)) res = longint'((1 << DW) - 1);
      return int'(res);
   endfunction

   always @(negedge clk) begin
      if (rst_n && d_if.out_valid && d_if.out_ready) begin
         if (sb.size() == 0) check("sb_unexpected", 64'(sb.size()), 64'd1);
         else begin
            m_e = sb.pop_front();
            check("out_idx",   64'(d_if.out_idx),   64'(m_e.idx));
            check("out_sign",  64'(d_if.out_sign),  64'(m_e.sign));
            check("out_delta", 64'(d_if.out_delta), 64'(m_e.delta));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && s_if.out_valid && s_if.out_ready) begin
         if (sb8.size() == 0) check("sb8_unexpected", 64'(sb8.size()), 64'd1);
         else begin
            m_e8 = sb8.pop_front();
            check("f8_idx",   64'(s_if.out_idx),   64'(m_e8.idx));
            check("f8_sign",  64'(s_if.out_sign),  64'(m_e8.sign));
            check("f8_delta", 64'(s_if.out_delta), 64'(m_e8.delta));
         end
      end
   end

   task automatic check_cleared(input string tag);
      check({tag, "_valid"}, 64'(d_if.out_valid), 64'd0);
      check({tag, "_idx"},   64'(d_if.out_idx),   64'd0);
      check({tag, "_sign"},  64'(d_if.out_sign),  64'd0);
      check({tag, "_delta"}, 64'(d_if.out_delta), 64'd0);
      check({tag, "_svec"},  64'(d_if.sign_vec),  64'd0);
      check({tag, "_dvec"},  64'(d_if.delta_vec), 64'd0);
      check({tag, "_busy"},  64'(d_if.busy),      64'd0);
      check({tag, "_done"},  64'(d_if.done),      64'd0);
   endtask

   // Full sweep on the main instance; optional stall on one neuron and a
   // stray start pulse mid-sweep plus scrambled inputs after the accepted start.
   task automatic run_sweep(input int av[N], input int ex[N], input int stall_idx,
                            input int stall_n, input int exp_done);
      logic [N*DW-1:0] pa;
      logic [N*DW-1:0] pe;
      logic [N*DW-1:0] exp_dv;
      logic [N-1:0]    exp_sv;
      int d;
      int c0;
      int left;
      int wd;
      for (int i = 0; i < N; i++) begin
         d = model_delta(av[i], ex[i], FW);
         pa[i*DW +: DW]     = DW'(av[i]);
         pe[i*DW +: DW]     = DW'(ex[i]);
         exp_dv[i*DW +: DW] = DW'(d);
         exp_sv[i]          = (av[i] < 0);
         sb.push_back('{idx: i, sign: (av[i] < 0), delta: d});
      end
      @(posedge clk); #1;
      d_if.start = 1'b1; d_if.add_val = pa; d_if.out_exp = pe; d_if.out_ready = 1'b1;
      @(posedge clk); #1;
      c0 = cyc;
      d_if.start   = 1'b0;
      d_if.add_val = (N*DW)'({$urandom, $urandom});
      d_if.out_exp = (N*DW)'({$urandom, $urandom});
      check("busy_after_start", 64'(d_if.busy), 64'd1);
      left = stall_n;
      wd = 0;
      while (!d_if.done && wd < 200) begin
         if (d_if.out_valid && int'(d_if.out_idx) == stall_idx && left > 0) begin
            check("stall_idx",   64'(d_if.out_idx),   64'(stall_idx));
            check("stall_delta", 64'(d_if.out_delta), 64'(exp_dv[stall_idx*DW +: DW]));
            check("stall_sign",  64'(d_if.out_sign),  64'(exp_sv[stall_idx]));
            d_if.out_ready = 1'b0;
            left--;
         end else begin
            d_if.out_ready = 1'b1;
         end
         d_if.start = (cyc - c0 == 4) ? 1'b1 : 1'b0;
         @(posedge clk); #1;
         wd++;
      end
      d_if.start = 1'b0;
      check("done_seen",  64'(d_if.done), 64'd1);
      check("done_cycle", 64'(cyc - c0 + 1), 64'(exp_done));
      check("sign_vec",   64'(d_if.sign_vec),  64'(exp_sv));
      check("delta_vec",  64'(d_if.delta_vec), 64'(exp_dv));
      @(posedge clk); #1;
      check("idle_busy",  64'(d_if.busy), 64'd0);
      check("done_pulse", 64'(d_if.done), 64'd0);
      check("sb_drained", 64'(sb.size()), 64'd0);
      check("hold_dvec",  64'(d_if.delta_vec), 64'(exp_dv));
   endtask

   int av_basic[N] = '{-199, 99, -23, 14, -100};
   int ex_basic[N] = '{499, 499, 499, 499, 499};
   int av_edge[N]  = '{0, -1, 511, -512, 0};
   int ex_edge[N]  = '{1023, 512, 1023, 1023, 300};
   int av_post[N]  = '{300, -300, 7, -7, 256};
   int ex_post[N]  = '{600, 100, 512, 513, 1000};

   initial begin
      d_if.start = 1'b0; d_if.add_val = '0; d_if.out_exp = '0; d_if.out_ready = 1'b0;
      s_if.start = 1'b0; s_if.add_val = '0; s_if.out_exp = '0; s_if.out_ready = 1'b0;
      #2;
      check_cleared("reset");
      check("f8_reset_busy", 64'(s_if.busy), 64'd0);
      #20 rst_n = 1'b1;

      run_sweep(av_basic, ex_basic, -1, 0, 2*N + 1);
      run_sweep(av_basic, ex_basic, 2, 3, 2*N + 4);
      run_sweep(av_edge, ex_edge, -1, 0, 2*N + 1);

      // Saturation and most-negative input on the FRAC_W=8 instance.
      sb8.push_back('{idx: 0, sign: 1'b0, delta: model_delta(511, 1023, FW8)});
      sb8.push_back('{idx: 1, sign: 1'b1, delta: model_delta(-512, 256, FW8)});
      @(posedge clk); #1;
      s_if.start = 1'b1; s_if.out_ready = 1'b1;
      s_if.add_val = {DW'(-512), DW'(511)};
      s_if.out_exp = {DW'(256), DW'(1023)};
      @(posedge clk); #1;
      s_if.start = 1'b0;
      for (int w = 0; w < 50 && !s_if.done; w++) begin
         @(posedge clk); #1;
      end
      check("f8_done",  64'(s_if.done), 64'd1);
      check("f8_svec",  64'(s_if.sign_vec), 64'd2);
      check("f8_dvec",  64'(s_if.delta_vec), {44'd0, 10'd512, 10'd1023});
      check("f8_drain", 64'(sb8.size()), 64'd0);

      // Asynchronous reset during the neuron 3 EMIT discards the sweep.
      for (int i = 0; i < N; i++)
         sb.push_back('{idx: i, sign: (av_basic[i] < 0), delta: model_delta(av_basic[i], ex_basic[i], FW)});
      @(posedge clk); #1;
      d_if.start = 1'b1; d_if.out_ready = 1'b1;
      for (int i = 0; i < N; i++) begin
         d_if.add_val[i*DW +: DW] = DW'(av_basic[i]);
         d_if.out_exp[i*DW +: DW] = DW'(ex_basic[i]);
      end
      @(posedge clk); #1;
      d_if.start = 1'b0;
      begin
         int w;
         w = 0;
         while (!(d_if.out_valid && d_if.out_idx == 3) && w < 50) begin
            @(posedge clk); #1;
            w++;
         end
         check("reach_emit3", 64'(d_if.out_idx), 64'd3);
      end
      #1 rst_n = 1'b0;
      #1;
      check_cleared("midrst");
      sb.delete();
      repeat (2) begin
         @(negedge clk);
         check("rst_no_done", 64'(d_if.done), 64'd0);
      end
      rst_n = 1'b1;
      run_sweep(av_post, ex_post, -1, 0, 2*N + 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/delta0_scheduler.md
# delta0_scheduler

Sequencing controller for the output-layer delta computation in weight optimization. It latches one error/derivative vector pair on `start` and shares a single multiplier across `N_OUT` output neurons. Each neuron's sign and delta magnitude is streamed to the weight-update stage over a valid/ready handshake. It also accumulates the full sign/delta result vectors and pulses `done` when the sweep completes.

## Interface
- `N_OUT`, default 5: number of output neurons.
- `DATA_W`, default 10: width of `add_val`, `out_exp` and delta elements.
- `FRAC_W`, default 9: fractional bits of `out_exp`; 1.0 = 2^FRAC_W.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request a sweep; sampled only in IDLE.
- `add_val`  in  N_OUT*DATA_W  signed errors; neuron i at `[i*DATA_W +: DATA_W]`.
- `out_exp`  in  N_OUT*DATA_W  unsigned activation derivatives; same packing.
- `out_valid`  out  1  per-neuron result valid.
- `out_ready`  in  1  downstream accepts the result.
- `out_idx`  out  $clog2(N_OUT)  neuron index of the current result.
- `out_sign`  out  1  1 = negative delta.
- `out_delta`  out  DATA_W  delta magnitude.
- `sign_vec`  out  N_OUT  accumulated signs; bit i = neuron i.
- `delta_vec`  out  N_OUT*DATA_W  accumulated magnitudes; same packing as inputs.
- `busy`  out  1  sweep in progress.
- `done`  out  1  one-cycle pulse after the last handshake.

## Operation
- FSM states are IDLE, CALC, EMIT and DONE. On reset, every output and register is 0 and the state is IDLE.
- IDLE → CALC when `start`=1.
  - `add_val` and `out_exp` are latched; later input changes are ignored.
  - idx is cleared to 0.
  - `sign_vec` and `delta_vec` are cleared to 0.
- CALC (1 cycle):
  - mag = |a| as an unsigned DATA_W value, where a = latched `add_val[idx]`; -2^(DATA_W-1) maps to 2^(DATA_W-1).
  - prod = mag * `out_exp[idx]` (2*DATA_W bits).
  - res = prod >> FRAC_W, saturated to 2^DATA_W-1.
  - Registered outputs: `out_delta`=res, `out_sign`=a[DATA_W-1], `out_idx`=idx. Go to EMIT.
- EMIT holds `out_valid`=1, with `out_idx`, `out_sign` and `out_delta` stable until `out_ready`=1.
  - On handshake: write sign/delta into `sign_vec[idx]` and `delta_vec[idx]`.
  - If idx = N_OUT-1, go to DONE; otherwise idx+1 → CALC.
  - `out_valid` drops in the cycle after the handshake.
- DONE: `done`=1 for one cycle, then IDLE. The result vectors hold until the next accepted `start`.
- `busy` = 1 in CALC, EMIT and DONE. `start` outside IDLE is ignored, not queued.
- Sign with zero magnitude: `out_sign` follows the MSB of `add_val` even when res = 0.
- Async reset mid-sweep: immediate return to IDLE with all outputs cleared. The partial results are discarded.

## Timing
- With `start` sampled high at edge 0 and `out_ready` held high:
  - CALC for neuron k occupies cycle 2k+1; EMIT/handshake for neuron k occupies cycle 2k+2.
  - `done` is high in cycle 2*N_OUT+1 (cycle 11 for N_OUT=5).
  - IDLE resumes and `busy` falls in cycle 2*N_OUT+2.
- Each cycle of `out_ready`=0 in EMIT adds exactly one cycle of latency.
- `start` held high continuously gives back-to-back sweeps; the next `start` is accepted in the first IDLE cycle.
- No combinational path from `out_ready` to `out_valid` or to the data outputs.

## Configuration
- `DELTA0_ROUND_EN`, when defined: res = (prod + 2^(FRAC_W-1)) >> FRAC_W, computed in 2*DATA_W+1 bits before saturation (round half up).
- When undefined: truncation, res = prod >> FRAC_W.
- The handshake, FSM and latency are identical in both builds.

## Test plan
- Basic sweep:
  - Stimulus: `add_val` = {-199, 99, -23, 14, -100}, all `out_exp`=499, `out_ready`=1.
  - Truncate build: deltas {193, 96, 22, 13, 97}, `sign_vec`=5'b10101 (bit0 = neuron 0).
  - `DELTA0_ROUND_EN` build: deltas {194, 96, 22, 14, 97}.
  - `done` in cycle 11; `out_idx` sequence 0..4.
- Backpressure: same stimulus, `out_ready` low for 3 cycles during the neuron 2 EMIT.
  - `out_valid`, `out_idx`=2 and `out_delta`=22 stay stable.
  - `done` is delayed to cycle 14.
- Saturation and edge case, with FRAC_W=8:
  - `add_val`=511, `out_exp`=1023 → `out_delta`=1023.
  - `add_val`=-512, `out_exp`=256 → `out_delta`=512, `out_sign`=1.
- Zero and ignored start:
  - `add_val`=0 → delta 0, sign 0.
  - `start` pulsed while `busy` → no restart; the vectors from the first sweep are intact.
  - Input changes after `start` do not affect the results.
- Reset mid-sweep: assert `rst_n`=0 during the neuron 3 EMIT.
  - All outputs go 0 immediately, with no `done`.
  - A new `start` after reset completes a full 5-neuron sweep.
